// File: rtl/ex_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
// Shared definitions for the iterative RV32M/RV64M multiply-divide unit:
// func3 operation codes, the controller state encoding and small decode
// helpers that tell which operands an operation treats as signed.
// ----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

  // M-extension func3 codes as they appear in the instruction word.
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Controller states.
  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // All divide/remainder codes have func3[2] set.
  function automatic logic isDivOp(input logic [2:0] func3);
    return func3[2];
  endfunction

  // Operand a is signed for everything except the fully unsigned ops.
  function automatic logic aIsSigned(input logic [2:0] func3);
    return (func3 != MD_MULHU) && (func3 != MD_DIVU) && (func3 != MD_REMU);
  endfunction

  // Operand b is signed like a, except MULHSU where b is unsigned.
  function automatic logic bIsSigned(input logic [2:0] func3);
    return aIsSigned(func3) && (func3 != MD_MULHSU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, try subtracting the divisor and keep the result only
// when it does not borrow.
//   rem_i          current partial remainder (always < divisor)
//   dividend_bit_i next dividend bit, MSB first
//   divisor_i      divisor magnitude
//   rem_o          next partial remainder
//   q_bit_o        quotient bit produced by this step
// ----------------------------------------------------------------------------
module ex_muldiv_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] partial;
  logic [XLEN:0] trial;

  // The partial value is below twice the divisor, so one extra bit is enough
  // to hold it, and the MSB of the trial difference is exactly the borrow.
  always_comb begin
    partial = {rem_i, dividend_bit_i};
    trial   = partial - {1'b0, divisor_i};
    q_bit_o = ~trial[XLEN];
    rem_o   = q_bit_o ? trial[XLEN-1:0] : partial[XLEN-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative M-extension multiply/divide unit sitting beside the EX-stage ALU.
// One operation at a time: operands are latched as sign + magnitude, the
// magnitude result is built by shift-add (multiply, MUL_STEP bits per cycle)
// or restoring division (one quotient bit per cycle), then signs are fixed up
// and the result is registered with a one-cycle done pulse.
//   clk, rst        clock and asynchronous active-high reset
//   ex_md_start     EX holds a valid M op this cycle
//   ex_md_func3     operation select (MUL..REMU)
//   ex_op_a/b       forwarded rs1/rs2 values
//   flush           kill the in-flight op
//   md_busy         stall request to the hazard unit
//   md_done         one-cycle pulse, md_result valid
//   md_result       registered result, held until the next done
// ----------------------------------------------------------------------------
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_md_start,
  input  logic [2:0]      ex_md_func3,
  input  logic [XLEN-1:0] ex_op_a,
  input  logic [XLEN-1:0] ex_op_b,
  input  logic            flush,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = XLEN + MUL_STEP;
  localparam logic [CW-1:0]   DIV_ITERS = CW'(XLEN);
  localparam logic [CW-1:0]   MUL_ITERS = CW'(XLEN / MUL_STEP);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [2:0]        func3_q, func3_d;
  logic              negA_q, negA_d;
  logic              negB_q, negB_d;
  logic [XLEN-1:0]   magB_q, magB_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            startOk;
  logic            aNeg, bNeg;
  logic [XLEN-1:0] aMag, bMag;
  logic            divZero, divOvf;
  logic [XLEN-1:0] specialRes;

  logic [PW-1:0]     addend;
  logic [PW-1:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;

  logic [XLEN-1:0]   remNext;
  logic              qBit;
  logic [2*XLEN-1:0] divNext;

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotFix, remFix;
  logic [XLEN-1:0]   fixResult;

  // Decode the incoming operation: operand signs and magnitudes, plus the
  // two division corner cases that finish without iterating. Negating the
  // most-negative value yields the same bit pattern, which is the correct
  // unsigned magnitude, so no extra width is needed.
  always_comb begin
    startOk    = ex_md_start & ~flush;
    aNeg       = aIsSigned(ex_md_func3) & ex_op_a[XLEN-1];
    bNeg       = bIsSigned(ex_md_func3) & ex_op_b[XLEN-1];
    aMag       = aNeg ? -ex_op_a : ex_op_a;
    bMag       = bNeg ? -ex_op_b : ex_op_b;
    divZero    = isDivOp(ex_md_func3) && (ex_op_b == '0);
    divOvf     = ((ex_md_func3 == MD_DIV) || (ex_md_func3 == MD_REM)) &&
                 (ex_op_a == MOST_NEG) && (ex_op_b == '1);
    specialRes = '0;
    if (divZero) begin
      specialRes = ex_md_func3[1] ? ex_op_a : '1;
    end else if (divOvf) begin
      specialRes = ex_md_func3[1] ? '0 : ex_op_a;
    end
  end

  // Multiply step: the low half of the accumulator holds the not-yet-used
  // multiplier bits, the high half the running sum. Add the multiplicand for
  // each of the MUL_STEP low bits, then shift the whole thing right.
  always_comb begin
    addend = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (acc_q[j]) begin
        addend = addend + (PW'(magB_q) << j);
      end
    end
    mulSum  = PW'(acc_q[2*XLEN-1:XLEN]) + addend;
    mulNext = {mulSum, acc_q[XLEN-1:MUL_STEP]};
  end

  // Divide step: the high half is the partial remainder, the low half the
  // dividend shifting out MSB-first while quotient bits shift in at the LSB.
  ex_muldiv_unit_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i         (acc_q[2*XLEN-1:XLEN]),
    .dividend_bit_i(acc_q[XLEN-1]),
    .divisor_i     (magB_q),
    .rem_o         (remNext),
    .q_bit_o       (qBit)
  );

  assign divNext = {remNext, acc_q[XLEN-2:0], qBit};

  // Sign correction and half selection once the magnitude result is ready.
  // The quotient takes the xor of the signs, the remainder the dividend's.
  always_comb begin
    product   = (negA_q ^ negB_q) ? -acc_q : acc_q;
    quotFix   = (negA_q ^ negB_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remFix    = negA_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fixResult = '0;
    case (func3_q)
      MD_MUL:                       fixResult = product[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixResult = product[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixResult = quotFix;
      default:                      fixResult = remFix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A flush wins over everything and drops back to IDLE,
  // which also makes a start that coincides with a flush a no-op.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (ex_md_start) begin
            state_d = (divZero || divOvf) ? MD_DONE : MD_CALC;
          end
        end
        MD_CALC: begin
          if (count_q == CW'(1)) begin
            state_d = MD_FIXUP;
          end
        end
        MD_FIXUP: state_d = MD_DONE;
        default:  state_d = MD_IDLE;
      endcase
    end
  end

  // FSM outputs. The IDLE term of busy is combinational so the pipeline
  // stalls in the very cycle the op is presented; busy drops in DONE so the
  // stalled instruction retires together with the result. Busy is also
  // forced low while reset is asserted.
  always_comb begin
    md_busy = ~rst & (((state_q == MD_IDLE) & startOk) |
                      (state_q == MD_CALC) | (state_q == MD_FIXUP));
    md_done = (state_q == MD_DONE);
  end

  assign md_result = result_q;

  // Datapath next-state: latch operands on start, iterate in CALC, and
  // register the result on the way into DONE unless the op is being flushed.
  always_comb begin
    func3_d  = func3_q;
    negA_d   = negA_q;
    negB_d   = negB_q;
    magB_d   = magB_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (startOk) begin
          func3_d = ex_md_func3;
          negA_d  = aNeg;
          negB_d  = bNeg;
          magB_d  = bMag;
          acc_d   = {{XLEN{1'b0}}, aMag};
          count_d = isDivOp(ex_md_func3) ? DIV_ITERS : MUL_ITERS;
          if (divZero || divOvf) begin
            result_d = specialRes;
          end
        end
      end
      MD_CALC: begin
        acc_d   = isDivOp(func3_q) ? divNext : mulNext;
        count_d = count_q - CW'(1);
      end
      MD_FIXUP: begin
        if (!flush) begin
          result_d = fixResult;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func3_q  <= '0;
      negA_q   <= 1'b0;
      negB_q   <= 1'b0;
      magB_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      func3_q  <= func3_d;
      negA_q   <= negA_d;
      negB_q   <= negB_d;
      magB_q   <= magB_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed bench for ex_muldiv_unit. Two instances share the clock and reset:
// one with MUL_STEP=1 (main tests) and one with MUL_STEP=4.
// Cycle 0 is the cycle in which start is presented and sampled at the
// following rising edge. Inputs change and outputs are sampled just after
// the falling edge.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  func3;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] result;

  logic        startF, flushF;
  logic [2:0]  func3F;
  logic [31:0] opAF, opBF;
  logic        busyF, doneF;
  logic [31:0] resultF;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_md_start(start),
    .ex_md_func3(func3),
    .ex_op_a    (opA),
    .ex_op_b    (opB),
    .flush      (flush),
    .md_busy    (busy),
    .md_done    (done),
    .md_result  (result)
  );

  ex_muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dutFast (
    .clk        (clk),
    .rst        (rst),
    .ex_md_start(startF),
    .ex_md_func3(func3F),
    .ex_op_a    (opAF),
    .ex_op_b    (opBF),
    .flush      (flushF),
    .md_busy    (busyF),
    .md_done    (doneF),
    .md_result  (resultF)
  );

  // Present one op, hold it while waiting for done (bounded), then drop start.
  // Reports the done cycle (-1 on timeout), the result, whether busy stayed
  // high before done, and busy in the done cycle.
  task automatic applyStimulus(input bit useFast, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] b,
                               output int doneCyc, output logic [31:0] res,
                               output bit busyOk, output logic busyAtDone);
    logic curBusy, curDone;
    doneCyc    = -1;
    res        = 'x;
    busyOk     = 1'b1;
    busyAtDone = 1'bx;
    @(negedge clk);
    if (useFast) begin
      startF = 1'b1; func3F = f; opAF = a; opBF = b;
    end else begin
      start = 1'b1; func3 = f; opA = a; opB = b;
    end
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      curBusy = useFast ? busyF : busy;
      curDone = useFast ? doneF : done;
      if (curDone === 1'b1) begin
        doneCyc    = c;
        res        = useFast ? resultF : result;
        busyAtDone = curBusy;
        break;
      end
      if (curBusy !== 1'b1) busyOk = 1'b0;
    end
    start  = 1'b0;
    startF = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b0, MD_MUL, 32'd7, 32'hFFFF_FFFD, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFEB) begin failures++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); end
    checks++;
    if (dc != 34) begin failures++; $display("[TB] FAIL mul_done_cycle: got %0d expected 34", dc); end
    checks++;
    if (bok !== 1'b1) begin failures++; $display("[TB] FAIL mul_busy_window: got %b expected 1 (busy high cycles 0..33)", bok); end
    checks++;
    if (bdone !== 1'b0) begin failures++; $display("[TB] FAIL mul_busy_at_done: got %b expected 0", bdone); end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL mul_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mul_high();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b0, MD_MULH, 32'h8000_0000, 32'h8000_0000, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h4000_0000) begin failures++; $display("[TB] FAIL mulh_result: got %h expected 40000000", r); end
    applyStimulus(1'b0, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL mulhu_result: got %h expected fffffffe", r); end
    applyStimulus(1'b0, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mulhsu_result: got %h expected ffffffff", r); end
  endtask

  task automatic test_div();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_result: got %h expected fffffffd", r); end
    checks++;
    if (dc != 34) begin failures++; $display("[TB] FAIL div_done_cycle: got %0d expected 34", dc); end
    applyStimulus(1'b0, MD_REM, 32'hFFFF_FFF9, 32'd2, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL rem_result: got %h expected ffffffff", r); end
    applyStimulus(1'b0, MD_DIVU, 32'hFFFF_FFFF, 32'h10, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h0FFF_FFFF) begin failures++; $display("[TB] FAIL divu_result: got %h expected 0fffffff", r); end
    applyStimulus(1'b0, MD_REMU, 32'd100, 32'd7, dc, r, bok, bdone);
    checks++;
    if (r !== 32'd2) begin failures++; $display("[TB] FAIL remu_result: got %h expected 00000002", r); end
  endtask

  task automatic test_special();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b0, MD_DIV, 32'd5, 32'd0, dc, r, bok, bdone);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div0_result: got %h expected ffffffff", r); end
    checks++;
    if (dc != 1) begin failures++; $display("[TB] FAIL div0_done_cycle: got %0d expected 1", dc); end
    applyStimulus(1'b0, MD_REM, 32'd5, 32'd0, dc, r, bok, bdone);
    checks++;
    if (r !== 32'd5) begin failures++; $display("[TB] FAIL rem0_result: got %h expected 00000005", r); end
    applyStimulus(1'b0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divovf_result: got %h expected 80000000", r); end
    checks++;
    if (dc != 1) begin failures++; $display("[TB] FAIL divovf_done_cycle: got %0d expected 1", dc); end
    applyStimulus(1'b0, MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h0) begin failures++; $display("[TB] FAIL removf_result: got %h expected 00000000", r); end
  endtask

  task automatic test_flush();
    int dc; logic [31:0] r; bit bok; logic bdone; bit doneSeen;
    // Establish a known nonzero result that the killed op must not disturb.
    applyStimulus(1'b0, MD_DIVU, 32'hFFFF_FFFF, 32'h10, dc, r, bok, bdone);
    @(negedge clk);
    start = 1'b1; func3 = MD_DIV; opA = 32'd1000; opB = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    doneSeen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) doneSeen = 1'b1;
    end
    checks++;
    if (doneSeen !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_done: got %b expected 0", doneSeen); end
    checks++;
    if (result !== 32'h0FFF_FFFF) begin failures++; $display("[TB] FAIL flush_result_held: got %h expected 0fffffff", result); end
    applyStimulus(1'b0, MD_MUL, 32'd2, 32'd3, dc, r, bok, bdone);
    checks++;
    if (r !== 32'd6) begin failures++; $display("[TB] FAIL after_flush_mul: got %h expected 00000006", r); end
  endtask

  task automatic test_reset_mid_op();
    int dc; logic [31:0] r; bit bok; logic bdone;
    @(negedge clk);
    start = 1'b1; func3 = MD_MUL; opA = 32'd5; opB = 32'd5;
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("[TB] FAIL midrst_result: got %h expected 00000000", result); end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, MD_MUL, 32'd3, 32'd3, dc, r, bok, bdone);
    checks++;
    if (r !== 32'd9) begin failures++; $display("[TB] FAIL midrst_next_mul: got %h expected 00000009", r); end
    checks++;
    if (dc != 34) begin failures++; $display("[TB] FAIL midrst_next_cycle: got %0d expected 34", dc); end
  endtask

  task automatic test_back_to_back();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b0, MD_MUL, 32'h0001_2345, 32'h100, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h0123_4500) begin failures++; $display("[TB] FAIL b2b_first: got %h expected 01234500", r); end
    applyStimulus(1'b0, MD_DIVU, 32'h0123_4500, 32'h100, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h0001_2345) begin failures++; $display("[TB] FAIL b2b_second: got %h expected 00012345", r); end
    checks++;
    if (dc != 34) begin failures++; $display("[TB] FAIL b2b_second_cycle: got %0d expected 34", dc); end
  endtask

  task automatic test_mul_step4();
    int dc; logic [31:0] r; bit bok; logic bdone;
    applyStimulus(1'b1, MD_MUL, 32'h0001_0000, 32'h0001_0000, dc, r, bok, bdone);
    checks++;
    if (r !== 32'h0) begin failures++; $display("[TB] FAIL step4_mul: got %h expected 00000000", r); end
    checks++;
    if (dc != 10) begin failures++; $display("[TB] FAIL step4_mul_cycle: got %0d expected 10", dc); end
    applyStimulus(1'b1, MD_MULHU, 32'h0001_0000, 32'h0001_0000, dc, r, bok, bdone);
    checks++;
    if (r !== 32'd1) begin failures++; $display("[TB] FAIL step4_mulhu: got %h expected 00000001", r); end
    checks++;
    if (dc != 10) begin failures++; $display("[TB] FAIL step4_mulhu_cycle: got %0d expected 10", dc); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; flush = 1'b0; func3 = '0; opA = '0; opB = '0;
    startF = 1'b0; flushF = 1'b0; func3F = '0; opAF = '0; opBF = '0;
    $display("[TB] starting ex_muldiv_unit bench");
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    test_mul_step4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M/RV64M multiply–divide unit attached to the EX stage alongside the single-cycle ALU. It accepts one M-extension operation at a time with post-forwarding operands, raises a stall request to the hazard unit while it computes, and returns the XLEN-bit result with a one-cycle done pulse. The EX result mux selects `md_result` when `md_done` is high. Multiplier throughput and data width are parametrised.

## Interface
- `XLEN`, 32: datapath width; 32 or 64.
- `MUL_STEP`, 1: multiplier bits retired per cycle; 1, 2 or 4; must divide XLEN.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_md_start`  in  1  EX holds a valid M op (opcode OP, func7 0000001).
- `ex_md_func3`  in  3  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU = 0..7.
- `ex_op_a`  in  XLEN  forwarded rs1 value.
- `ex_op_b`  in  XLEN  forwarded rs2 value.
- `flush`  in  1  kill the in-flight op (taken branch/jump).
- `md_busy`  out  1  stall request to the hazard unit.
- `md_done`  out  1  one-cycle pulse; `md_result` valid.
- `md_result`  out  XLEN  registered result; holds its value until the next done.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: `ex_md_start`=1 and `flush`=0 → latch func3, operand signs and magnitudes.
  - Divisor zero → DONE. Quotient all-ones, remainder = dividend.
  - Signed overflow (DIV/REM, a = most-negative, b = −1) → DONE. Quotient = a, remainder 0.
  - Otherwise → CALC.
- CALC: iteration counter N = XLEN/MUL_STEP for mul, XLEN for div.
  - Mul: shift-add on magnitudes into a 2·XLEN accumulator.
  - Div: restoring, one quotient bit per cycle.
  - Counter reaching 0 → FIXUP.
- FIXUP: apply sign correction.
  - Product negated when signs differ. MULHSU treats only a as signed; MULHU and DIVU/REMU are unsigned.
  - Quotient sign = sa^sb; remainder sign = sa.
  - Select the low half for MUL and the high half for MULH*. → DONE.
- DONE: `md_result` registered, `md_done`=1. → IDLE unconditionally. `ex_md_start` is ignored in this state.
- `md_busy` = (IDLE & ex_md_start & ~flush) | CALC | FIXUP. The IDLE term is combinational so the stall takes effect in the start cycle. `md_busy` is 0 in DONE, which releases the pipeline in the same cycle the result is consumed.
- `ex_md_start` in CALC/FIXUP is ignored; inputs are held by the stall.
- `flush` in any state → IDLE at the next edge. No `md_done` for the killed op; `md_result` unchanged.
- `flush` with `ex_md_start` in IDLE: the start is ignored.

## Timing
- Cycle 0 = IDLE cycle with start sampled.
- Normal op: CALC in cycles 1..N, FIXUP in N+1, `md_done` in N+2.
  - XLEN=32, MUL_STEP=1: mul and div done at cycle 34.
  - MUL_STEP=4: mul done at cycle 10.
- Special-case div: `md_done` at cycle 1.
- `md_busy` high in cycles 0..N+1, low in N+2.
- A back-to-back M op can start the cycle after DONE.
- `rst` asserted: state IDLE immediately.
  - `md_busy`, `md_done`, `md_result`, counter and accumulators all reset to 0.
  - Mid-operation reset discards the op.

## Structure
- Add to the shared `define.vh`:
  - func3 codes: `MD_MUL`..`MD_REMU`
  - state encodings: `MD_IDLE`, `MD_CALC`, `MD_FIXUP`, `MD_DONE`
- Optional sub-module `md_div_step`: combinational single restoring-division step (trial subtract, quotient bit, next remainder). Instantiated once.
- All other logic is inline in `ex_muldiv_unit`.

## Test plan
All cases use XLEN=32, MUL_STEP=1 unless noted.
- MUL 7 × 0xFFFFFFFD (−3) → `md_result` 0xFFFFFFEB, `md_done` at cycle 34, `md_busy` high cycles 0..33.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division and remainder:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF, done at cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- `flush` at cycle 10 of a DIV → `md_busy` low at cycle 11, no `md_done`, `md_result` unchanged. A following MUL 2×3 → 6.
- `rst` pulse at cycle 5 of a MUL → all outputs 0 asynchronously, then a clean MUL 3×3 → 9. With MUL_STEP=4, MUL 0x10000 × 0x10000 → 0 with done at cycle 10, and MULHU of the same operands → 1.
